// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled majority vote,
// optional parity, 1/2 stop bits, false-start rejection and break handling.
module uart_rx_param #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rxddata,
  output logic                 rdone,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DivW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SampW = $clog2(OVERSAMPLE);

  localparam logic [DivW-1:0]  DivMax   = DivW'(DIV - 1);
  localparam logic [SampW-1:0] SampLast = SampW'(OVERSAMPLE - 1);
  localparam logic [SampW-1:0] SampA    = SampW'(OVERSAMPLE / 2 - 1);
  localparam logic [SampW-1:0] SampB    = SampW'(OVERSAMPLE / 2);
  localparam logic [SampW-1:0] SampC    = SampW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]       DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]       StopLast = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
  end
  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_param: CLK_FREQ too low for BAUD*OVERSAMPLE");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e                state_q, state_d;
  logic                  rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [DivW-1:0]       div_cnt_q, div_cnt_d;
  logic [SampW-1:0]      samp_cnt_q, samp_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop_err_q, stop_err_d;
  logic [DATA_BITS-1:0]  rxddata_q, rxddata_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rdone_q, rdone_d;

  logic tick, mid, vote, start_edge, exp_par, stop_err_all;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  assign tick       = (div_cnt_q == DivMax);
  assign mid        = tick && (samp_cnt_q == SampC);
  // Third vote comes straight from the line at the last of the three sample points.
  assign vote       = (s0_q & s1_q) | (s0_q & rxd_sync_q) | (s1_q & rxd_sync_q);
  assign start_edge = rxd_prev_q & ~rxd_sync_q;
  assign exp_par    = (^shift_q) ^ (PARITY == 1);
  assign stop_err_all = stop_err_q | ~vote;

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    stop_err_d   = stop_err_q;
    rxddata_d    = rxddata_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rdone_d      = 1'b0;

    if (state_q == StIdle) begin
      div_cnt_d  = '0;
      samp_cnt_d = '0;
    end else if (tick) begin
      div_cnt_d  = '0;
      samp_cnt_d = (samp_cnt_q == SampLast) ? '0 : samp_cnt_q + SampW'(1);
    end else begin
      div_cnt_d  = div_cnt_q + DivW'(1);
    end

    if (tick && samp_cnt_q == SampA) s0_d = rxd_sync_q;
    if (tick && samp_cnt_q == SampB) s1_d = rxd_sync_q;

    // Every bit is resolved at its own mid-sample; bit boundaries need no tracking.
    unique case (state_q)
      StIdle: begin
        if (start_edge) state_d = StStart;
      end
      StStart: begin
        if (mid) begin
          bit_cnt_d = '0;
          state_d   = vote ? StIdle : StData;
        end
      end
      StData: begin
        if (mid) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d  = '0;
            stop_err_d = 1'b0;
            state_d    = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (mid) begin
          par_bit_d = vote;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (mid) begin
          if (bit_cnt_q == StopLast) begin
            rxddata_d    = shift_q;
            frame_err_d  = stop_err_all;
            parity_err_d = (PARITY != 0) && (par_bit_q != exp_par);
            rdone_d      = 1'b1;
            state_d      = rxd_sync_q ? StIdle : StBreak;
          end else begin
            stop_err_d = stop_err_all;
            bit_cnt_d  = bit_cnt_q + 4'd1;
          end
        end
      end
      StBreak: begin
        if (rxd_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      div_cnt_q    <= '0;
      samp_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      rxddata_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rdone_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      stop_err_q   <= stop_err_d;
      rxddata_q    <= rxddata_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rdone_q      <= rdone_d;
    end
  end

  assign rxddata    = rxddata_q;
  assign rdone      = rdone_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != StIdle);

endmodule
